ifetch_bp: RTL and testbench

Parametrised instruction-fetch stage with a dynamic branch predictor. It replaces the fixed 16-bit, always-not-taken fetch unit.
- Holds the PC and computes the next PC from: pending redirect, jr_i redirect, predicted-taken branch target, or PC+1.
- Maintains a table of saturating counters (the branch history table) that is updated when branches resolve downstream.
- Sits between instruction memory (combinational read of instr_i at pc_o) and the IF/ID pipeline register.

---
 rtl/ifetch_bp_pkg.sv | 37 +++
 rtl/ifetch_bp_if.sv | 33 +++
 rtl/ifetch_bp_bht.sv | 42 ++++
 rtl/ifetch_bp.sv | 112 +++++++++++
 tb/tb_ifetch_bp.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_bp_pkg.sv
// Shared definitions for the instruction-fetch stage: branch opcodes, saturating
// counter arithmetic and immediate sign extension for the 16-bit branch encodings.
package ifetch_pkg;

    localparam int unsigned CTR_MAX_W = 8;

    typedef enum logic [4:0] {
        OP_B    = 5'b00010,
        OP_BEQZ = 5'b00100,
        OP_BNEZ = 5'b00101
    } opcode_e;

    typedef logic [CTR_MAX_W-1:0] ctr_t;

    function automatic ctr_t inc_sat(input ctr_t v, input int unsigned w);
        ctr_t max_v;
        max_v = ctr_t'((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + ctr_t'(1);
    endfunction

    function automatic ctr_t dec_sat(input ctr_t v);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

    // B carries an 11-bit offset, the conditional branches an 8-bit one.
    function automatic logic [15:0] imm_ext(input logic [15:0] instr);
        logic [15:0] r;
        if (instr[15:11] == OP_B) r = {{5{instr[10]}}, instr[10:0]};
        else                      r = {{8{instr[7]}}, instr[7:0]};
        return r;
    endfunction

    function automatic logic is_cond_branch(input logic [4:0] op);
        return (op == OP_BEQZ) || (op == OP_BNEZ);
    endfunction

endpackage

// File: rtl/ifetch_bp_if.sv
// Fetch-stage bus: stall/redirect controls, instruction, branch resolution and
// the fetch outputs. master = fetch unit, slave = surrounding pipeline.
interface ifetch_bp_if #(
    parameter int unsigned DATA_W = 16
);
    logic              stall_pc_i;
    logic              jr_i;
    logic [DATA_W-1:0] address_jr_i;
    logic [DATA_W-1:0] instr_i;
    logic              resolve_valid_i;
    logic [DATA_W-1:0] resolve_pc_i;
    logic              resolve_taken_i;
    logic              resolve_pred_i;
    logic [DATA_W-1:0] resolve_target_i;
    logic              fetch_valid_o;
    logic              preresult_o;
    logic              redirect_o;
    logic [DATA_W-1:0] pc_o;
    logic [DATA_W-1:0] pcplus1_o;
    logic [DATA_W-1:0] epc_o;

    modport master (
        input  stall_pc_i, jr_i, address_jr_i, instr_i,
        input  resolve_valid_i, resolve_pc_i, resolve_taken_i, resolve_pred_i, resolve_target_i,
        output fetch_valid_o, preresult_o, redirect_o, pc_o, pcplus1_o, epc_o
    );

    modport slave (
        output stall_pc_i, jr_i, address_jr_i, instr_i,
        output resolve_valid_i, resolve_pc_i, resolve_taken_i, resolve_pred_i, resolve_target_i,
        input  fetch_valid_o, preresult_o, redirect_o, pc_o, pcplus1_o, epc_o
    );
endinterface

// File: rtl/ifetch_bp_bht.sv
// Branch history table: array of saturating counters with one combinational
// read port and one synchronous update port; async active-low reset.
module ifetch_bht
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CTR_W = 2,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [CTR_W-1:0] rd_ctr_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((32'd1 << (CTR_W - 1)) - 32'd1);

    logic [CTR_W-1:0] ctr_q [DEPTH];
    logic [CTR_W-1:0] ctr_d [DEPTH];
    ctr_t             cur;
    ctr_t             nxt;

    // Read sees the registered value, so a same-cycle update shows up next cycle.
    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_comb begin
        ctr_d = ctr_q;
        cur   = ctr_t'(ctr_q[upd_idx_i]);
        nxt   = upd_taken_i ? inc_sat(cur, CTR_W) : dec_sat(cur);
        if (upd_valid_i) ctr_d[upd_idx_i] = CTR_W'(nxt);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
        end else begin
            ctr_q <= ctr_d;
        end
    end
endmodule

// File: rtl/ifetch_bp.sv
// Instruction fetch with branch prediction. Define IFETCH_DYNAMIC_BP_EN for
// counter-based prediction of conditional branches; otherwise they predict not-taken.
module ifetch_bp
    import ifetch_pkg::*;
#(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       BHT_DEPTH = 16,
    parameter int unsigned       CTR_W     = 2,
    parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
    input logic         CLK,
    input logic         RST,
    ifetch_bp_if.master bus
);
    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    if (BHT_DEPTH < 2 || (BHT_DEPTH & (BHT_DEPTH - 1)) != 0 ||
        CTR_W < 1 || CTR_W > CTR_MAX_W || DATA_W < 16) begin : g_bad_param
        $error("ifetch_bp: unsupported parameter set");
    end

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] pc_lock_q, pc_lock_d;
    logic [DATA_W-1:0] pend_pc_q, pend_pc_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              pending_q, pending_d;

    logic [4:0]        opcode;
    logic              is_b, is_cond, cond_taken, preresult;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] pcplus1, br_target, recover_pc, redirect_pc, seq_pc;
    logic              mispredict, redirect;

    assign opcode  = bus.instr_i[15:11];
    assign is_b    = (opcode == OP_B);
    assign is_cond = is_cond_branch(opcode);
    assign imm16   = imm_ext(bus.instr_i[15:0]);

`ifdef IFETCH_DYNAMIC_BP_EN
    logic [CTR_W-1:0] ctr_rd;

    ifetch_bht #(
        .DEPTH (BHT_DEPTH),
        .CTR_W (CTR_W)
    ) u_bht (
        .CLK         (CLK),
        .RST         (RST),
        .rd_idx_i    (pc_q[IDX_W-1:0]),
        .rd_ctr_o    (ctr_rd),
        .upd_valid_i (bus.resolve_valid_i),
        .upd_idx_i   (bus.resolve_pc_i[IDX_W-1:0]),
        .upd_taken_i (bus.resolve_taken_i)
    );

    assign cond_taken = ctr_rd[CTR_W-1];
`else
    assign cond_taken = 1'b0;
`endif

    always_comb begin
        pcplus1     = pc_q + DATA_W'(1);
        br_target   = pcplus1 + DATA_W'($signed(imm16));
        preresult   = is_b | (is_cond & cond_taken);
        mispredict  = bus.resolve_valid_i & (bus.resolve_taken_i != bus.resolve_pred_i);
        recover_pc  = bus.resolve_taken_i ? bus.resolve_target_i : bus.resolve_pc_i + DATA_W'(1);
        redirect    = mispredict | bus.jr_i;
        redirect_pc = mispredict ? recover_pc : bus.address_jr_i;
        // The first edge after reset only validates the fetch; the PC stays put.
        seq_pc      = !fetch_valid_q ? pc_q : (preresult ? br_target : pcplus1);

        pc_d          = pc_q;
        pc_lock_d     = pc_lock_q;
        pend_pc_d     = pend_pc_q;
        fetch_valid_d = fetch_valid_q;
        pending_d     = pending_q;

        if (!bus.stall_pc_i) begin
            fetch_valid_d = 1'b1;
            pc_lock_d     = pc_q;
            pending_d     = 1'b0;
            if (redirect)       pc_d = redirect_pc;
            else if (pending_q) pc_d = pend_pc_q;
            else                pc_d = seq_pc;
        end else if (redirect) begin
            pending_d = 1'b1;
            pend_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q          <= RESET_PC;
            pc_lock_q     <= RESET_PC;
            pend_pc_q     <= RESET_PC;
            fetch_valid_q <= 1'b0;
            pending_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pc_lock_q     <= pc_lock_d;
            pend_pc_q     <= pend_pc_d;
            fetch_valid_q <= fetch_valid_d;
            pending_q     <= pending_d;
        end
    end

    assign bus.fetch_valid_o = fetch_valid_q;
    assign bus.preresult_o   = preresult;
    assign bus.redirect_o    = redirect;
    assign bus.pc_o          = pc_q;
    assign bus.pcplus1_o     = pcplus1;
    assign bus.epc_o         = redirect ? pc_lock_q : pc_q;
endmodule

// File: tb/tb_ifetch_bp.sv
// Directed scoreboard bench for ifetch_bp; expectations adapt to IFETCH_DYNAMIC_BP_EN.
module tb_ifetch_bp;
    import ifetch_pkg::*;

`ifdef IFETCH_DYNAMIC_BP_EN
    localparam bit DYN = 1'b1;
`else
    localparam bit DYN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifetch_bp_if #(.DATA_W(16)) bus ();

    ifetch_bp #(
        .DATA_W    (16),
        .BHT_DEPTH (16),
        .CTR_W     (2),
        .RESET_PC  (16'h0000)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0x%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.stall_pc_i       = 1'b0;
        bus.jr_i             = 1'b0;
        bus.address_jr_i     = '0;
        bus.instr_i          = '0;
        bus.resolve_valid_i  = 1'b0;
        bus.resolve_pc_i     = '0;
        bus.resolve_taken_i  = 1'b0;
        bus.resolve_pred_i   = 1'b0;
        bus.resolve_target_i = '0;
    endtask

    task automatic goto_pc(input logic [15:0] a);
        bus.jr_i         = 1'b1;
        bus.address_jr_i = a;
        push("goto_pc", {16'h0, a});
        tick();
        pop_chk(bus.pc_o);
        bus.jr_i = 1'b0;
    endtask

    task automatic resolve(input logic [15:0] rpc, input logic taken, input logic pred, input int n);
        bus.resolve_valid_i = 1'b1;
        bus.resolve_pc_i    = rpc;
        bus.resolve_taken_i = taken;
        bus.resolve_pred_i  = pred;
        for (int i = 0; i < n; i++) tick();
        bus.resolve_valid_i = 1'b0;
    endtask

    initial begin
        clr_inputs();
        rst_n = 1'b0;
        #2;
        push("rst_pc", 0);      pop_chk(bus.pc_o);
        push("rst_fv", 0);      pop_chk(bus.fetch_valid_o);
        push("rst_redir", 0);   pop_chk(bus.redirect_o);
        push("rst_epc", 0);     pop_chk(bus.epc_o);
        push("rst_pcplus1", 1); pop_chk(bus.pcplus1_o);
        #10 rst_n = 1'b1;

        push("first_pc", 0); push("first_fv", 1);
        tick();
        pop_chk(bus.pc_o); pop_chk(bus.fetch_valid_o);
        for (int i = 1; i <= 5; i++) begin
            push("seq_pc", i);
            tick();
            pop_chk(bus.pc_o);
        end

        // cold conditional branch at pc 5, imm +3
        bus.instr_i = 16'h2003;
        push("cold_pre", 0); #1 pop_chk(bus.preresult_o);
        push("cold_next", 6); tick(); pop_chk(bus.pc_o);
        bus.instr_i = '0;

        bus.resolve_target_i = 16'd9;
        bus.resolve_valid_i = 1'b1; bus.resolve_pc_i = 16'd5;
        bus.resolve_taken_i = 1'b1; bus.resolve_pred_i = 1'b1;
        push("resolve_no_redir", 0); #1 pop_chk(bus.redirect_o);
        push("resolve_pc", 8); tick(); tick(); pop_chk(bus.pc_o);
        bus.resolve_valid_i = 1'b0;

        bus.jr_i = 1'b1; bus.address_jr_i = 16'd5;
        push("jr_redir", 1); push("jr_epc", 7);
        #1 pop_chk(bus.redirect_o); pop_chk(bus.epc_o);
        push("jr_pc", 5); tick(); pop_chk(bus.pc_o);
        bus.jr_i = 1'b0;

        bus.instr_i = 16'h2003;
        push("warm_pre", DYN ? 1 : 0); #1 pop_chk(bus.preresult_o);
        push("warm_next", DYN ? 9 : 6); tick(); pop_chk(bus.pc_o);
        bus.instr_i = '0;

        // mispredict while at pc 10
        goto_pc(16'd10);
        bus.resolve_valid_i = 1'b1; bus.resolve_pc_i = 16'd5;
        bus.resolve_taken_i = 1'b0; bus.resolve_pred_i = 1'b1;
        push("mis_redir", 1); push("mis_epc", DYN ? 9 : 6);
        #1 pop_chk(bus.redirect_o); pop_chk(bus.epc_o);
        push("mis_pc", 6); tick(); pop_chk(bus.pc_o);
        bus.resolve_valid_i = 1'b0;
        push("epc_plain", 6); #1 pop_chk(bus.epc_o);

        // jr under stall is held pending
        bus.stall_pc_i = 1'b1; bus.jr_i = 1'b1; bus.address_jr_i = 16'h0040;
        push("stall_pc1", 6); tick(); pop_chk(bus.pc_o);
        push("stall_pc2", 6); tick(); pop_chk(bus.pc_o);
        bus.stall_pc_i = 1'b0; bus.jr_i = 1'b0;
        push("unstall_redir", 0); #1 pop_chk(bus.redirect_o);
        push("pending_pc", 16'h0040); tick(); pop_chk(bus.pc_o);
        push("after_pending", 16'h0041); tick(); pop_chk(bus.pc_o);

        bus.stall_pc_i = 1'b1; bus.jr_i = 1'b1; bus.address_jr_i = 16'h0050;
        tick();
        bus.address_jr_i = 16'h0060;
        tick();
        bus.stall_pc_i = 1'b0; bus.jr_i = 1'b0;
        push("pending_overwrite", 16'h0060); tick(); pop_chk(bus.pc_o);

        // mispredict beats jr
        bus.resolve_valid_i = 1'b1; bus.resolve_pc_i = 16'd7; bus.resolve_taken_i = 1'b1;
        bus.resolve_pred_i = 1'b0; bus.resolve_target_i = 16'h0020;
        bus.jr_i = 1'b1; bus.address_jr_i = 16'h0040;
        push("both_redir", 1); #1 pop_chk(bus.redirect_o);
        push("both_pc", 16'h0020); tick(); pop_chk(bus.pc_o);
        clr_inputs();

        // unconditional B, negative offset and PC wrap
        bus.instr_i = 16'h17FE;
        push("b_pre", 1); #1 pop_chk(bus.preresult_o);
        push("b_neg", 16'h001F); tick(); pop_chk(bus.pc_o);
        bus.instr_i = '0;
        goto_pc(16'hFFFE);
        bus.instr_i = 16'h1005;
        push("wrap_pcplus1", 16'hFFFF); #1 pop_chk(bus.pcplus1_o);
        push("b_wrap", 16'h0004); tick(); pop_chk(bus.pc_o);
        bus.instr_i = '0;

        // BNEZ with negative imm8 at index 7 (counter now 2)
        goto_pc(16'h0017);
        bus.instr_i = 16'h28F0;
        push("bnez_pre", DYN ? 1 : 0); #1 pop_chk(bus.preresult_o);
        push("bnez_next", DYN ? 16'h0008 : 16'h0018); tick(); pop_chk(bus.pc_o);
        bus.instr_i = '0;

        // saturation high at index 12
        resolve(16'd12, 1'b1, 1'b1, 5);
        resolve(16'd12, 1'b0, 1'b0, 1);
        goto_pc(16'd12);
        bus.instr_i = 16'h2003;
        push("sat_pre", DYN ? 1 : 0); #1 pop_chk(bus.preresult_o);
        push("sat_next", DYN ? 16 : 13); tick(); pop_chk(bus.pc_o);
        goto_pc(16'd12);
        bus.instr_i = 16'h3003;
        push("nonbranch_pre", 0); #1 pop_chk(bus.preresult_o);
        push("nonbranch_next", 13); tick(); pop_chk(bus.pc_o);
        bus.instr_i = '0;

        // saturation low at index 3, then same-cycle read/update
        resolve(16'd3, 1'b0, 1'b0, 2);
        resolve(16'd3, 1'b1, 1'b1, 1);
        goto_pc(16'd3);
        bus.instr_i = 16'h2003;
        bus.resolve_valid_i = 1'b1; bus.resolve_pc_i = 16'd3;
        bus.resolve_taken_i = 1'b1; bus.resolve_pred_i = 1'b1;
        push("low_sat_pre", 0); #1 pop_chk(bus.preresult_o);
        push("low_sat_next", 4); tick(); pop_chk(bus.pc_o);
        bus.resolve_valid_i = 1'b0; bus.instr_i = '0;
        goto_pc(16'd3);
        bus.instr_i = 16'h2003;
        push("rd_after_upd_pre", DYN ? 1 : 0); #1 pop_chk(bus.preresult_o);
        bus.instr_i = '0;

        // reset mid-operation drops pending redirect and counters
        bus.stall_pc_i = 1'b1; bus.jr_i = 1'b1; bus.address_jr_i = 16'h0077;
        tick();
        clr_inputs();
        rst_n = 1'b0;
        #1;
        push("mid_rst_pc", 0); pop_chk(bus.pc_o);
        push("mid_rst_fv", 0); pop_chk(bus.fetch_valid_o);
        #2 rst_n = 1'b1;
        push("mid_rst_first", 0); tick(); pop_chk(bus.pc_o);
        push("mid_rst_second", 1); tick(); pop_chk(bus.pc_o);
        goto_pc(16'd12);
        bus.instr_i = 16'h2003;
        push("mid_rst_ctr_pre", 0); #1 pop_chk(bus.preresult_o);
        bus.instr_i = '0;

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
